// File: rtl/baej_fc_pkg.sv
// Shared constants and FSM encoding for the call-frame spill/fill engine.
package baej_fc_pkg;

  localparam int WORD_W      = 16;
  localparam int FRAME_WORDS = 15;
  localparam int FRAME_W     = WORD_W * FRAME_WORDS;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SPILL   = 2'd1;
  localparam logic [1:0] FILL    = 2'd2;
  localparam logic [1:0] RESTORE = 2'd3;

endpackage

// File: rtl/fc_frame_stack_if.sv
// Control-unit / register-file side bundle of the frame stack.
interface fc_frame_stack_if #(
  parameter int DEPTH = 8
);
  import baej_fc_pkg::*;

  localparam int DEPTH_W = $clog2(DEPTH + 1);

  logic               call;
  logic               ret;
  logic [FRAME_W-1:0] fc_save;
  logic [FRAME_W-1:0] fc_restore;
  logic               restore;
  logic               busy;
  logic               full;
  logic               empty;
  logic [DEPTH_W-1:0] depth;
  logic               overflow;
  logic               underflow;

  modport master (
    output call, ret, fc_save,
    input  fc_restore, restore, busy, full, empty, depth, overflow, underflow
  );

  modport slave (
    input  call, ret, fc_save,
    output fc_restore, restore, busy, full, empty, depth, overflow, underflow
  );

endinterface

// File: rtl/fc_stack_ram.sv
// Single-port frame RAM: synchronous write, registered (read-first) read data.
module fc_stack_ram
  import baej_fc_pkg::*;
#(
  parameter int WORDS  = 120,
  parameter int ADDR_W = $clog2(WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/fc_frame_stack.sv
// Call-frame spill/fill engine. Optional macro FC_STACK_ZEROFILL_EN turns a
// ret on an empty stack into a restore of an all-zero frame.
module fc_frame_stack
  import baej_fc_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input logic             clk,
  input logic             reset_n,
  fc_frame_stack_if.slave fc
);

  localparam int SP_W      = $clog2(DEPTH + 1);
  localparam int RAM_WORDS = DEPTH * FRAME_WORDS;
  localparam int ADDR_W    = $clog2(RAM_WORDS);

  logic [1:0]         state;
  logic [SP_W-1:0]    sp;
  logic [3:0]         idx;
  logic [3:0]         wordIdx;
  logic [FRAME_W-1:0] shadow;
  logic [FRAME_W-1:0] fcRestore;
  logic               ovfPulse;
  logic               unfPulse;
  logic               isFull;
  logic               isEmpty;
  logic               ramWe;
  logic [ADDR_W-1:0]  ramAddr;
  logic [WORD_W-1:0]  ramWdata;
  logic [WORD_W-1:0]  ramRdata;

  assign isFull  = (sp == SP_W'(DEPTH));
  assign isEmpty = (sp == '0);

  // FILL runs one extra cycle (idx == FRAME_WORDS) to catch the last read; hold the address in range there.
  assign wordIdx  = (idx == 4'(FRAME_WORDS)) ? 4'(FRAME_WORDS - 1) : idx;
  assign ramAddr  = ADDR_W'(sp) * ADDR_W'(FRAME_WORDS) + ADDR_W'(wordIdx);
  assign ramWe    = (state == SPILL);
  assign ramWdata = shadow[WORD_W*int'(wordIdx) +: WORD_W];

  fc_stack_ram #(
    .WORDS (RAM_WORDS),
    .ADDR_W(ADDR_W)
  ) uRam (
    .clk  (clk),
    .we   (ramWe),
    .addr (ramAddr),
    .wdata(ramWdata),
    .rdata(ramRdata)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      sp        <= '0;
      idx       <= '0;
      fcRestore <= '0;
      ovfPulse  <= 1'b0;
      unfPulse  <= 1'b0;
    end else begin
      ovfPulse <= 1'b0;
      unfPulse <= 1'b0;
      case (state)
        IDLE: begin
          if (fc.call) begin
            if (isFull) begin
              ovfPulse <= 1'b1;
            end else begin
              idx   <= '0;
              state <= SPILL;
            end
          end else if (fc.ret) begin
            if (!isEmpty) begin
              sp    <= sp - 1'b1;
              idx   <= '0;
              state <= FILL;
            end else begin
              unfPulse <= 1'b1;
`ifdef FC_STACK_ZEROFILL_EN
              fcRestore <= '0;
              state     <= RESTORE;
`endif
            end
          end
        end
        SPILL: begin
          idx <= idx + 4'd1;
          if (idx == 4'(FRAME_WORDS - 1)) begin
            sp    <= sp + 1'b1;
            state <= IDLE;
          end
        end
        FILL: begin
          idx <= idx + 4'd1;
          if (idx == 4'(FRAME_WORDS)) begin
            fcRestore <= {ramRdata, shadow[FRAME_W-WORD_W-1:0]};
            state     <= RESTORE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Frame datapath: snapshot on call accept, word-by-word assembly during FILL.
  always_ff @(posedge clk) begin
    if (state == IDLE && fc.call && !isFull) begin
      shadow <= fc.fc_save;
    end else if (state == FILL && idx != '0) begin
      shadow[WORD_W*(int'(idx)-1) +: WORD_W] <= ramRdata;
    end
  end

  assign fc.fc_restore = fcRestore;
  assign fc.restore    = (state == RESTORE);
  assign fc.busy       = (state != IDLE);
  assign fc.full       = isFull;
  assign fc.empty      = isEmpty;
  assign fc.depth      = sp;
  assign fc.overflow   = ovfPulse;
  assign fc.underflow  = unfPulse;

endmodule
